// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg -- shared definitions for the ALU / multiply-divide unit.
//   * opcode constants for control_in
//   * FSM state encoding of the top-level request/response controller
//   * operation select and iteration-counter width of the iterative datapath
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_REMU = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MD_MUL  = 2'd0,
    MD_DIVU = 2'd1,
    MD_REMU = 2'd2
  } md_op_e;

  // Wide enough to count WIDTH-1 for the largest legal WIDTH (64).
  localparam int CNT_W = 7;

endpackage

// File: rtl/alu_muldiv_iter.sv
// -----------------------------------------------------------------------------
// alu_muldiv_iter -- iterative shift-add multiplier / restoring divider.
// One bit per clock; exactly WIDTH iterations after the start pulse.
//   clk, reset  : clock, asynchronous active-low reset
//   start       : load operands and begin (only pulsed while idle)
//   op          : MD_MUL (low WIDTH bits), MD_DIVU, MD_REMU
//   A, B        : operands, sampled on start
//   done        : high during the final iteration cycle
//   result      : value the final iteration produces (valid while done = 1)
// Divide by zero needs no special case: every trial subtraction succeeds,
// giving an all-ones quotient and a remainder equal to A.
// -----------------------------------------------------------------------------
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  md_op_e           op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic             busy;
  logic [CNT_W-1:0] count;
  md_op_e           op_q;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [WIDTH-1:0] quo, rem, divisor;

  logic [WIDTH-1:0] acc_next, quo_next, rem_next;
  logic [WIDTH:0]   rem_shift, diff;

  always_comb begin
    acc_next  = mplier[0] ? acc + mcand : acc;
    rem_shift = {rem, quo[WIDTH-1]};
    diff      = rem_shift - {1'b0, divisor};
    // A negative trial difference restores the shifted remainder; it then
    // fits in WIDTH bits because it is below the divisor.
    if (diff[WIDTH]) begin
      rem_next = rem_shift[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
    case (op_q)
      MD_DIVU: result = quo_next;
      MD_REMU: result = rem_next;
      default: result = acc_next;
    endcase
  end

  assign done = busy && (count == CNT_W'(WIDTH - 1));

  // NOTE: the datapath registers are reset as well so that result never
  // carries X into the top level, even though it is only sampled with done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy    <= 1'b0;
      count   <= '0;
      op_q    <= MD_MUL;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      quo     <= '0;
      rem     <= '0;
      divisor <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      count   <= '0;
      op_q    <= op;
      acc     <= '0;
      mcand   <= A;
      mplier  <= B;
      quo     <= A;
      rem     <= '0;
      divisor <= B;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      quo    <= quo_next;
      rem    <= rem_next;
      if (done) begin
        busy  <= 1'b0;
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_muldiv_unit.sv
// -----------------------------------------------------------------------------
// alu_muldiv_unit -- handshaked ALU with optional iterative MUL/DIVU/REMU.
//   clk, reset            : clock, asynchronous active-low reset
//   A, B, control_in      : operands and opcode, sampled on in_valid & in_ready
//   in_valid / in_ready   : request handshake (in_ready only in IDLE)
//   result, zero, illegal : registered response, held until out_ready
//   out_valid / out_ready : response handshake
// Build option: define ALU_MULDIV_EN to implement MUL/DIVU/REMU through
// alu_muldiv_iter (WIDTH+1 edge latency). Without it those codes are illegal
// and the CALC state is unreachable.
// -----------------------------------------------------------------------------
module alu_muldiv_unit
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic [CTRL_W-1:0] control_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  result,
  output logic              zero,
  output logic              illegal,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int SH_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] alu_res;
  logic             alu_illegal;
  logic             is_md;
  logic             md_done;
  logic [WIDTH-1:0] md_result;
  logic [SH_W-1:0]  shamt;

  assign shamt    = B[SH_W-1:0];
  assign in_ready = (state_q == ST_IDLE);

`ifdef ALU_MULDIV_EN
  md_op_e md_op;
`endif

  // Single-cycle datapath and opcode decode.
  // NOTE: every output of this block gets a default first so no latch forms.
  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    is_md       = 1'b0;
`ifdef ALU_MULDIV_EN
    md_op       = MD_MUL;
`endif
    case (control_in)
      CTRL_W'(OP_AND):  alu_res = A & B;
      CTRL_W'(OP_OR):   alu_res = A | B;
      CTRL_W'(OP_ADD):  alu_res = A + B;
      CTRL_W'(OP_SUB):  alu_res = A - B;
      CTRL_W'(OP_XOR):  alu_res = A ^ B;
      CTRL_W'(OP_SLL):  alu_res = A << shamt;
      CTRL_W'(OP_SRL):  alu_res = A >> shamt;
      CTRL_W'(OP_SRA):  alu_res = $unsigned($signed(A) >>> shamt);
      CTRL_W'(OP_SLT):  alu_res = WIDTH'($signed(A) < $signed(B));
      CTRL_W'(OP_SLTU): alu_res = WIDTH'(A < B);
`ifdef ALU_MULDIV_EN
      CTRL_W'(OP_MUL):  begin is_md = 1'b1; md_op = MD_MUL;  end
      CTRL_W'(OP_DIVU): begin is_md = 1'b1; md_op = MD_DIVU; end
      CTRL_W'(OP_REMU): begin is_md = 1'b1; md_op = MD_REMU; end
`else
      CTRL_W'(OP_MUL), CTRL_W'(OP_DIVU), CTRL_W'(OP_REMU): alu_illegal = 1'b1;
`endif
      default:          alu_illegal = 1'b1;
    endcase
  end

`ifdef ALU_MULDIV_EN
  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (in_ready && in_valid && is_md),
    .op     (md_op),
    .A      (A),
    .B      (B),
    .done   (md_done),
    .result (md_result)
  );
`else
  assign md_done   = 1'b0;
  assign md_result = '0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = is_md ? ST_CALC : ST_DONE;
      ST_CALC: if (md_done)   state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Response registers: loaded when entering DONE, held until released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid && !is_md) begin
          result    <= alu_res;
          zero      <= (alu_res == '0);
          illegal   <= alu_illegal;
          out_valid <= 1'b1;
        end
        ST_CALC: if (md_done) begin
          result    <= md_result;
          zero      <= (md_result == '0);
          illegal   <= 1'b0;
          out_valid <= 1'b1;
        end
        ST_DONE: if (out_ready) out_valid <= 1'b0;
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_muldiv_unit -- directed self-checking bench for alu_muldiv_unit
// (WIDTH = 32). MUL/DIVU/REMU expectations follow ALU_MULDIV_EN: iterative
// results with 33-edge latency when defined, illegal after one edge otherwise.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] A, B;
  logic [3:0]   control_in;
  logic         in_valid, in_ready;
  logic [W-1:0] result;
  logic         zero, illegal, out_valid, out_ready;

  int checks = 0;
  int errors = 0;

  alu_muldiv_unit #(.WIDTH(W), .CTRL_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .A          (A),
    .B          (B),
    .control_in (control_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .result     (result),
    .zero       (zero),
    .illegal    (illegal),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [W-1:0] a, b, exp;
  } vec_t;

  // Presents one request (caller is 1 ns after an edge, DUT in IDLE) and
  // counts edges from acceptance until out_valid, bounded at 200.
  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, b,
                       output int lat, output bit rdy_low);
    control_in = c; A = a; B = b; in_valid = 1'b1;
    rdy_low = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready) rdy_low = 1'b0;
  endtask

  task automatic release_resp();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Single-cycle vector: latency 1, result, zero, illegal.
  task automatic run_vec(input vec_t v, input logic exp_ill);
    int lat; bit rl;
    issue(v.op, v.a, v.b, lat, rl);
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL %s latency: got %0d expected 1", v.name, lat);
    end
    checks++;
    if (result !== v.exp) begin
      errors++; $display("FAIL %s result: got %h expected %h", v.name, result, v.exp);
    end
    checks++;
    if (zero !== (v.exp == '0)) begin
      errors++; $display("FAIL %s zero: got %b expected %b", v.name, zero, v.exp == '0);
    end
    checks++;
    if (illegal !== exp_ill) begin
      errors++; $display("FAIL %s illegal: got %b expected %b", v.name, illegal, exp_ill);
    end
    release_resp();
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; control_in = '0;
    #3;
    checks++;
    if ({in_ready, out_valid, zero, illegal} !== 4'b1000 || result !== '0) begin
      errors++;
      $display("FAIL reset_state: rdy/ov/zero/ill=%b result=%h expected 1000 / 0",
               {in_ready, out_valid, zero, illegal}, result);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_logic_arith();
    vec_t v[8];
    v[0] = '{"sub_zero", 4'b0110, 32'd5,          32'd5,          32'h0000_0000};
    v[1] = '{"sub_wrap", 4'b0110, 32'd3,          32'd5,          32'hFFFF_FFFE};
    v[2] = '{"add_wrap", 4'b0010, 32'hFFFF_FFFF,  32'd2,          32'h0000_0001};
    v[3] = '{"and",      4'b0000, 32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200};
    v[4] = '{"or",       4'b0001, 32'hF000_0000,  32'h0000_000F,  32'hF000_000F};
    v[5] = '{"xor",      4'b0011, 32'hAAAA_AAAA,  32'hFFFF_FFFF,  32'h5555_5555};
    v[6] = '{"sll_mask", 4'b0100, 32'h0000_0001,  32'h0000_0021,  32'h0000_0002};
    v[7] = '{"srl_31",   4'b0101, 32'h8000_0000,  32'h0000_003F,  32'h0000_0001};
    for (int i = 0; i < 8; i++) run_vec(v[i], 1'b0);
  endtask

  task automatic test_shift_compare();
    vec_t v[4];
    v[0] = '{"sra",       4'b0111, 32'h8000_0000, 32'h0000_0021, 32'hC000_0000};
    v[1] = '{"slt_neg",   4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    v[2] = '{"sltu_neg",  4'b1001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    v[3] = '{"sltu_less", 4'b1001, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
    for (int i = 0; i < 4; i++) run_vec(v[i], 1'b0);
  endtask

  task automatic test_illegal();
    vec_t v[2];
    v[0] = '{"illegal_1111", 4'b1111, 32'h1234_5678, 32'h9, 32'h0};
    v[1] = '{"illegal_1101", 4'b1101, 32'hFFFF_FFFF, 32'h1, 32'h0};
    for (int i = 0; i < 2; i++) run_vec(v[i], 1'b1);
  endtask

  task automatic test_muldiv();
    vec_t v[6];
    int lat; bit rl;
    v[0] = '{"mul_wrap",  4'b1010, 32'hFFFF_FFFF, 32'd3,   32'hFFFF_FFFD};
    v[1] = '{"mul",       4'b1010, 32'd12345,     32'd678, 32'h007F_B6F6};
    v[2] = '{"divu_by0",  4'b1011, 32'd7,         32'd0,   32'hFFFF_FFFF};
    v[3] = '{"remu_by0",  4'b1100, 32'd7,         32'd0,   32'd7};
    v[4] = '{"divu",      4'b1011, 32'd100,       32'd7,   32'd14};
    v[5] = '{"remu",      4'b1100, 32'd100,       32'd7,   32'd2};
`ifdef ALU_MULDIV_EN
    for (int i = 0; i < 6; i++) begin
      issue(v[i].op, v[i].a, v[i].b, lat, rl);
      checks++;
      if (lat !== W + 1) begin
        errors++; $display("FAIL %s latency: got %0d expected %0d", v[i].name, lat, W + 1);
      end
      checks++;
      if (rl !== 1'b1) begin
        errors++; $display("FAIL %s in_ready_low: got in_ready high during operation, expected low", v[i].name);
      end
      checks++;
      if (result !== v[i].exp || illegal !== 1'b0 || zero !== 1'b0) begin
        errors++;
        $display("FAIL %s result: got %h ill=%b zero=%b expected %h ill=0 zero=0",
                 v[i].name, result, illegal, zero, v[i].exp);
      end
      release_resp();
    end
`else
    for (int i = 0; i < 6; i++) begin
      v[i].exp = '0;
      run_vec(v[i], 1'b1);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int lat; bit rl;
    issue(4'b0010, 32'd3, 32'd4, lat, rl);
    // Hold DONE with a competing request on the inputs.
    control_in = 4'b0011; A = 32'd1; B = 32'd3; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== 32'd7 || zero !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: ov=%b result=%h zero=%b in_ready=%b expected 1 00000007 0 0",
                 i, out_valid, result, zero, in_ready);
      end
    end
    // Release edge: the pending request must not be taken on this edge.
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL no_bypass: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd2) begin
      errors++; $display("FAIL next_accept: out_valid=%b result=%h expected 1 00000002", out_valid, result);
    end
    release_resp();
  endtask

  task automatic test_reset_mid();
    bit seen;
`ifdef ALU_MULDIV_EN
    control_in = 4'b1010; A = 32'd5; B = 32'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
`else
    control_in = 4'b0010; A = 32'd1; B = 32'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
`endif
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL busy_before_reset: in_ready=%b expected 0", in_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: ov=%b in_ready=%b result=%h zero=%b expected 0 1 0 0",
               out_valid, in_ready, result, zero);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset: in_ready=%b expected 1", in_ready);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL abandoned_op: out_valid seen=%b expected 0", seen);
    end
    run_vec('{"post_reset_sub", 4'b0110, 32'd9, 32'd4, 32'd5}, 1'b0);
  endtask

  initial begin
    test_reset();
    test_logic_arith();
    test_shift_compare();
    test_illegal();
    test_muldiv();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_unit.md
ALU_MULDIV_UNIT -- requirements
Module: alu_muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values: powers of two, 8 to 64.
REQ-002 SHALL have parameter CTRL_W, default 4, width of control_in.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports A and B, input, WIDTH each, operands; sampled only on an accepted request.
REQ-006 SHALL have port control_in, input, CTRL_W, operation code.
REQ-007 SHALL have ports in_valid (input, 1) and in_ready (output, 1), request handshake.
REQ-008 SHALL have port result, output, WIDTH, registered result.
REQ-009 SHALL have port zero, output, 1, result == 0.
REQ-010 SHALL have port illegal, output, 1, unsupported control_in code.
REQ-011 SHALL have ports out_valid (output, 1) and out_ready (input, 1), response handshake.

Function
REQ-012 SHALL decode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 XOR, 0100 SLL, 0101 SRL, 0111 SRA, 1000 SLT (signed), 1001 SLTU, 1010 MUL (low WIDTH bits), 1011 DIVU, 1100 REMU; all other codes illegal.
REQ-013 SHALL wrap ADD/SUB/MUL modulo 2^WIDTH; shift amount = B[log2(WIDTH)-1:0]; SLT/SLTU yield 1 or 0 zero-extended.
REQ-014 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; in_ready = 1 only in IDLE.
REQ-015 SHALL, on accepted single-cycle op (incl. illegal), go IDLE -> DONE; out_valid asserted on the next edge (latency 1).
REQ-016 SHALL, on accepted MUL/DIVU/REMU, go IDLE -> CALC, iterate exactly WIDTH cycles, then DONE; out_valid asserts WIDTH+1 edges after acceptance.
REQ-017 SHALL hold result, zero, illegal, out_valid stable in DONE until out_ready = 1, then return to IDLE on that edge.
REQ-018 SHALL NOT accept a new request in the cycle DONE is released (no bypass); next acceptance earliest one cycle later.
REQ-019 SHALL, for DIVU with B = 0, return all ones; REMU with B = 0 returns A; no illegal flag.
REQ-020 SHALL, for illegal codes, return result 0, zero 1, illegal 1.
REQ-021 SHALL ignore in_valid, A, B, control_in outside IDLE.

Reset
REQ-022 SHALL, while reset = 0, force state IDLE, result 0, zero 0, illegal 0, out_valid 0, iteration counter 0, asynchronously.
REQ-023 SHALL abandon any CALC/DONE operation on reset with no response produced; in_ready = 1 first cycle after release.

Configuration
REQ-024 SHALL honour macro ALU_MULDIV_EN: defined -> MUL/DIVU/REMU and CALC state implemented per REQ-016/019.
REQ-025 SHALL, without ALU_MULDIV_EN, treat 1010/1011/1100 as illegal (REQ-020), omit the iterative datapath, CALC unreachable.

Structure
REQ-026 SHALL place opcode constants, FSM state encoding and the iteration-count width in shared package alu_pkg.
REQ-027 SHALL place the shift-add multiplier / restoring divider in sub-module alu_muldiv_iter (start, op, A, B -> done, result), instantiated only under ALU_MULDIV_EN.

Verification
REQ-028 SHALL test: WIDTH=32, SUB A=5 B=5 -> one cycle later out_valid=1, result 0, zero 1.
REQ-029 SHALL test: MUL A=0xFFFF_FFFF B=3 -> out_valid after 33 edges, result 0xFFFF_FFFD, in_ready 0 throughout.
REQ-030 SHALL test: DIVU A=7 B=0 -> 0xFFFF_FFFF; REMU A=7 B=0 -> 7; DIVU 100/7 -> 14, REMU -> 2.
REQ-031 SHALL test: SRA A=0x8000_0000 B=0x21 -> 0xC000_0000; SLT A=-1 B=1 -> 1; SLTU same -> 0.
REQ-032 SHALL test: out_ready held 0 for 5 cycles in DONE -> outputs stable, new in_valid ignored; reset mid-CALC -> out_valid 0, in_ready 1 after release.
REQ-033 SHALL test: control_in 1111 -> illegal 1, result 0; rebuild without ALU_MULDIV_EN, MUL -> illegal 1 after 1 cycle.
